// File: rtl/rule_unpacker_pkg.sv
// Shared types and constants for the rule stream path.
// Holds the rule/flit geometry, the null rule ID, the packet metadata
// record and the unpacker state encoding.
package rule_unpacker_pkg;

   localparam int RULE_W = 16;
   localparam int SLOTS  = 32;
   localparam int FLIT_W = RULE_W * SLOTS;
   localparam int IDX_W  = $clog2(SLOTS);

   // Rule ID 0 marks an empty slot, and on the output it marks a null entry
   localparam logic [RULE_W-1:0] NULL_RULE = '0;

   typedef struct packed {
      logic [15:0] pkt_id;
      logic [15:0] pkt_len;
      logic [7:0]  flags;
   } metadata_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_NULL  = 2'd2
   } unpack_state_t;

   // One bit per slot, set where the slot holds a nonzero rule ID
   function automatic logic [SLOTS-1:0] slot_mask(input logic [FLIT_W-1:0] flit);
      logic [SLOTS-1:0] m;
      m = '0;
      for (int s = 0; s < SLOTS; s++) begin
         m[s] = |flit[s*RULE_W +: RULE_W];
      end
      return m;
   endfunction

   function automatic logic [RULE_W-1:0] get_slot(input logic [FLIT_W-1:0] flit,
                                                  input logic [IDX_W-1:0]  idx);
      return flit[int'(idx)*RULE_W +: RULE_W];
   endfunction

endpackage

// File: rtl/rule_unpacker_slot_penc.sv
// Lowest-set-bit priority encoder over the per-slot nonzero bitmap.
// Also reports whether any bit is set and whether exactly one is set,
// which is what decides the last entry of a flit.
module rule_slot_penc
   import rule_unpacker_pkg::*;
(
   input  logic [SLOTS-1:0] mask,
   output logic [IDX_W-1:0] idx,
   output logic             any,
   output logic             one
);

   // Scan from the top so the lowest set bit wins
   always_comb begin
      idx = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

   assign any = |mask;
   assign one = any & ~(|(mask & (mask - SLOTS'(1))));

endmodule

// File: rtl/rule_unpacker.sv
// Serialises the packed rule IDs of each 512-bit rule flit into one rule
// per cycle. Zero slots are dropped; each packet closes with exactly one
// entry flagged out_rule_last (a null entry if the closing flit is empty).
// Optional build macro: RULE_UNPACK_STATS_EN enables the handshake counters
// stats_rules / stats_null_pkts; without it both read 0.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no flit held, input always ready
// ST_DRAIN | flit held in flit_q, mask_q = remaining nonzero slots
// ST_NULL  | closing flit was empty, null entry (data 0, last) pending
module rule_unpacker
   import rule_unpacker_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_usr_valid,
   input  logic              in_usr_sop,
   input  logic              in_usr_eop,
   input  logic [FLIT_W-1:0] in_usr_data,
   input  logic [5:0]        in_usr_empty,
   output logic              in_usr_ready,
   output logic              out_rule_valid,
   output logic [RULE_W-1:0] out_rule_data,
   output logic              out_rule_sop,
   output logic              out_rule_last,
   input  logic              out_rule_ready,
   output logic [31:0]       stats_rules,
   output logic [31:0]       stats_null_pkts
);

   unpack_state_t     state;
   logic [FLIT_W-1:0] flit_q;
   logic [SLOTS-1:0]  mask_q;
   logic              eop_q;
   logic              sop_pend;
   logic [IDX_W-1:0]  cur_idx_q;
   logic              one_q;

   logic [FLIT_W-1:0] flit_nxt;
   logic [SLOTS-1:0]  mask_nxt;
   logic              eop_nxt;
   logic              sop_nxt;
   logic [IDX_W-1:0]  idx_nxt;
   logic              any_nxt;
   logic              one_nxt;

   logic              flit_take;
   logic              rule_take;
   logic              unused_empty;

   // The empty field has no meaning for a rule list
   assign unused_empty = ^in_usr_empty;

   // Taking the last entry of a flit frees the holding register in the same
   // cycle, so a new flit can be accepted without a bubble
   assign in_usr_ready = (state == ST_IDLE)
                       | ((state == ST_DRAIN) & one_q & out_rule_ready)
                       | ((state == ST_NULL) & out_rule_ready);

   assign flit_take = in_usr_valid & in_usr_ready;
   assign rule_take = out_rule_valid & out_rule_ready;

   // Next holding-register contents: retire the emitted slot, then overlay
   // a newly accepted flit
   always_comb begin
      flit_nxt = flit_q;
      mask_nxt = mask_q;
      eop_nxt  = eop_q;
      sop_nxt  = sop_pend;
      if (rule_take) begin
         if (state == ST_DRAIN) begin
            mask_nxt = mask_q & ~(SLOTS'(1) << cur_idx_q);
         end
         sop_nxt = 1'b0;
      end
      if (flit_take) begin
         flit_nxt = in_usr_data;
         mask_nxt = slot_mask(in_usr_data);
         eop_nxt  = in_usr_eop;
         sop_nxt  = sop_nxt | in_usr_sop;
      end
   end

   rule_slot_penc u_penc (
      .mask (mask_nxt),
      .idx  (idx_nxt),
      .any  (any_nxt),
      .one  (one_nxt)
   );

   // Unpacker FSM; the output entry is registered from the next mask so it
   // appears one cycle after acceptance and holds while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         flit_q         <= '0;
         mask_q         <= '0;
         eop_q          <= 1'b0;
         sop_pend       <= 1'b0;
         cur_idx_q      <= '0;
         one_q          <= 1'b0;
         out_rule_valid <= 1'b0;
         out_rule_data  <= NULL_RULE;
         out_rule_sop   <= 1'b0;
         out_rule_last  <= 1'b0;
      end else begin
         flit_q   <= flit_nxt;
         mask_q   <= mask_nxt;
         eop_q    <= eop_nxt;
         sop_pend <= sop_nxt;
         if (flit_take || rule_take) begin
            if (any_nxt) begin
               state          <= ST_DRAIN;
               cur_idx_q      <= idx_nxt;
               one_q          <= one_nxt;
               out_rule_valid <= 1'b1;
               out_rule_data  <= get_slot(flit_nxt, idx_nxt);
               out_rule_sop   <= sop_nxt;
               out_rule_last  <= eop_nxt & one_nxt;
            end else if (flit_take && eop_nxt) begin
               state          <= ST_NULL;
               one_q          <= 1'b0;
               out_rule_valid <= 1'b1;
               out_rule_data  <= NULL_RULE;
               out_rule_sop   <= sop_nxt;
               out_rule_last  <= 1'b1;
            end else begin
               // Retired the last slot, or dropped an empty mid-packet flit
               state          <= ST_IDLE;
               one_q          <= 1'b0;
               out_rule_valid <= 1'b0;
               out_rule_data  <= NULL_RULE;
               out_rule_sop   <= 1'b0;
               out_rule_last  <= 1'b0;
            end
         end
      end
   end

`ifdef RULE_UNPACK_STATS_EN
   // Count emitted rules and null-closed packets on the output handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stats_rules     <= '0;
         stats_null_pkts <= '0;
      end else if (rule_take) begin
         if (out_rule_data != NULL_RULE) begin
            stats_rules <= stats_rules + 32'd1;
         end else begin
            stats_null_pkts <= stats_null_pkts + 32'd1;
         end
      end
   end
`else
   assign stats_rules     = 32'd0;
   assign stats_null_pkts = 32'd0;
`endif

endmodule

// File: tb/tb_rule_unpacker.sv
`timescale 1ns/1ps
module tb_rule_unpacker;
   import rule_unpacker_pkg::*;

   typedef struct packed {
      logic [RULE_W-1:0] data;
      logic              sop;
      logic              last;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_usr_valid = 1'b0;
   logic              in_usr_sop = 1'b0;
   logic              in_usr_eop = 1'b0;
   logic [FLIT_W-1:0] in_usr_data = '0;
   logic [5:0]        in_usr_empty = '0;
   logic              in_usr_ready;
   logic              out_rule_valid;
   logic [RULE_W-1:0] out_rule_data;
   logic              out_rule_sop;
   logic              out_rule_last;
   logic              out_rule_ready = 1'b1;
   logic [31:0]       stats_rules;
   logic [31:0]       stats_null_pkts;

   int   checks = 0;
   int   errors = 0;
   int   rdy_mode = 0;
   ent_t exp_q[$];
   logic m_pend = 1'b0;
   int   m_rules = 0;
   int   m_nulls = 0;
   logic prev_stall = 1'b0;
   ent_t stall_ent;

   rule_unpacker dut (
      .clk             (clk),
      .rst             (rst),
      .in_usr_valid    (in_usr_valid),
      .in_usr_sop      (in_usr_sop),
      .in_usr_eop      (in_usr_eop),
      .in_usr_data     (in_usr_data),
      .in_usr_empty    (in_usr_empty),
      .in_usr_ready    (in_usr_ready),
      .out_rule_valid  (out_rule_valid),
      .out_rule_data   (out_rule_data),
      .out_rule_sop    (out_rule_sop),
      .out_rule_last   (out_rule_last),
      .out_rule_ready  (out_rule_ready),
      .stats_rules     (stats_rules),
      .stats_null_pkts (stats_null_pkts)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic finish_sim();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired", name);
      finish_sim();
   endtask

   // Reference: nonzero slots in ascending order; the last of them closes
   // the packet on an eop flit; an empty eop flit yields one null entry
   task automatic model_flit(input logic sop, input logic eop,
                             input logic [FLIT_W-1:0] d, output int n);
      logic [RULE_W-1:0] v;
      int last_nz;
      n = 0;
      last_nz = -1;
      if (sop) m_pend = 1'b1;
      for (int s = 0; s < SLOTS; s++) begin
         v = d[s*RULE_W +: RULE_W];
         if (v != 0) last_nz = s;
      end
      for (int s = 0; s < SLOTS; s++) begin
         v = d[s*RULE_W +: RULE_W];
         if (v != 0) begin
            exp_q.push_back('{data: v, sop: m_pend, last: eop && (s == last_nz)});
            m_pend = 1'b0;
            m_rules++;
            n++;
         end
      end
      if (n == 0 && eop) begin
         exp_q.push_back('{data: '0, sop: m_pend, last: 1'b1});
         m_pend = 1'b0;
         m_nulls++;
         n = 1;
      end
   endtask

   // Called just after a posedge; returns just after the accepting posedge
   task automatic send(input logic sop, input logic eop,
                       input logic [FLIT_W-1:0] d, output int waits);
      int   n;
      logic idle_before;
      in_usr_valid = 1'b1;
      in_usr_sop   = sop;
      in_usr_eop   = eop;
      in_usr_data  = d;
      in_usr_empty = 6'($urandom);
      waits = 0;
      forever begin
         @(negedge clk);
         if (in_usr_ready) break;
         waits++;
         if (waits > 4000) timeout_fail("send_ready");
         @(posedge clk);
         #1;
      end
      idle_before = !out_rule_valid;
      model_flit(sop, eop, d, n);
      @(posedge clk);
      #1;
      in_usr_valid = 1'b0;
      if (idle_before) chk("latency_valid", out_rule_valid, n > 0);
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while (out_rule_valid || exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         c++;
         if (c > 5000) timeout_fail("drain");
      end
   endtask

   function automatic logic [FLIT_W-1:0] gen_flit(input int dens);
      logic [FLIT_W-1:0] f;
      f = '0;
      for (int s = 0; s < SLOTS; s++) begin
         if ($urandom_range(0, 99) < dens) f[s*RULE_W +: RULE_W] = RULE_W'($urandom_range(1, 65535));
      end
      return f;
   endfunction

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 1) out_rule_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: compares each output handshake against the scoreboard head
   // and checks that a stalled entry stays put
   always @(negedge clk) begin
      ent_t cur;
      ent_t e;
      cur = '{data: out_rule_data, sop: out_rule_sop, last: out_rule_last};
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", out_rule_valid, 1'b1);
            chk("stall_hold", cur, stall_ent);
         end
         if (out_rule_valid && out_rule_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_entry: got %0h with nothing expected", cur);
            end else begin
               e = exp_q.pop_front();
               chk("entry", cur, e);
            end
         end
         prev_stall = out_rule_valid && !out_rule_ready;
         stall_ent  = cur;
      end
   end

   initial begin
      #900000;
      timeout_fail("global_watchdog");
   end

   initial begin
      logic [FLIT_W-1:0] d;
      int w;
      int maxw;
      int cnt;
      int nf;
      int dens;

      #1;
      chk("reset_valid", out_rule_valid, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_in_ready", in_usr_ready, 1'b1);
      chk("reset_out_valid", out_rule_valid, 1'b0);
      chk("reset_stats_rules", stats_rules, 32'd0);
      chk("reset_stats_null", stats_null_pkts, 32'd0);

      // Three rules in slots 0, 3, 31
      d = '0;
      d[0*RULE_W +: RULE_W]  = 16'h0011;
      d[3*RULE_W +: RULE_W]  = 16'h0022;
      d[31*RULE_W +: RULE_W] = 16'h0033;
      send(1'b1, 1'b1, d, w);
      chk("t1_first_data", out_rule_data, 16'h0011);
      chk("t1_first_sop", out_rule_sop, 1'b1);
      cnt = 0;
      while (out_rule_valid && cnt < 100) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("t1_cycles", cnt, 3);
      wait_idle();

      // Empty single-flit packet
      send(1'b1, 1'b1, '0, w);
      chk("t2_null_data", out_rule_data, 16'h0000);
      chk("t2_null_last", out_rule_last, 1'b1);
      wait_idle();
`ifdef RULE_UNPACK_STATS_EN
      chk("t2_stats_null", stats_null_pkts, 32'd1);
`else
      chk("t2_stats_null", stats_null_pkts, 32'd0);
`endif

      // Two-flit packet closed by an empty flit
      d = '0;
      d[5*RULE_W +: RULE_W] = 16'd7;
      send(1'b1, 1'b0, d, w);
      chk("t3_last_clear", out_rule_last, 1'b0);
      send(1'b0, 1'b1, '0, w);
      wait_idle();

      // Back-to-back one-rule packets
      maxw = 0;
      for (int i = 0; i < 6; i++) begin
         d = '0;
         d[$urandom_range(0, SLOTS-1)*RULE_W +: RULE_W] = RULE_W'(i + 100);
         send(1'b1, 1'b1, d, w);
         if (w > maxw) maxw = w;
      end
      chk("t4_no_bubble", maxw, 0);
      wait_idle();

      // Four rules with the downstream toggling ready
      d = '0;
      d[1*RULE_W +: RULE_W]  = 16'h0a01;
      d[9*RULE_W +: RULE_W]  = 16'h0a02;
      d[17*RULE_W +: RULE_W] = 16'h0a03;
      d[30*RULE_W +: RULE_W] = 16'h0a04;
      send(1'b1, 1'b1, d, w);
      cnt = 0;
      while (out_rule_valid && cnt < 100) begin
         out_rule_ready = (cnt % 2 == 1);
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("t5_cycles", cnt, 8);
      out_rule_ready = 1'b1;
      wait_idle();

      // Reset while the second of four rules is on the output
      send(1'b1, 1'b1, d, w);
      @(posedge clk);
      #2;
      chk("t6_second", out_rule_data, 16'h0a02);
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", out_rule_valid, 1'b0);
      exp_q.delete();
      m_pend  = 1'b0;
      m_rules = 0;
      m_nulls = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t6_in_ready", in_usr_ready, 1'b1);
      d = '0;
      d[12*RULE_W +: RULE_W] = 16'h0bbb;
      send(1'b1, 1'b1, d, w);
      chk("t6_sop", out_rule_sop, 1'b1);
      chk("t6_last", out_rule_last, 1'b1);
      wait_idle();

      // Random packets with random downstream backpressure
      rdy_mode = 1;
      for (int p = 0; p < 120; p++) begin
         nf = $urandom_range(1, 3);
         for (int f = 0; f < nf; f++) begin
            case ($urandom_range(0, 3))
               0: dens = 0;
               1: dens = 5;
               2: dens = 30;
               default: dens = 100;
            endcase
            d = gen_flit(dens);
            send((f == 0) || ($urandom_range(0, 19) == 0), f == nf - 1, d, w);
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
         end
      end
      rdy_mode = 0;
      out_rule_ready = 1'b1;
      wait_idle();
      chk("final_queue_empty", exp_q.size(), 0);
`ifdef RULE_UNPACK_STATS_EN
      chk("final_stats_rules", stats_rules, 32'(m_rules));
      chk("final_stats_null", stats_null_pkts, 32'(m_nulls));
`else
      chk("final_stats_rules", stats_rules, 32'd0);
      chk("final_stats_null", stats_null_pkts, 32'd0);
`endif
      finish_sim();
   end

endmodule
